// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared arbiter state encoding and master index type
package bus_pkg;

  localparam int MIDX_W = 2;

  typedef logic [MIDX_W-1:0] midx_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } bus_state_e;

endpackage

// File: rtl/count_reg.sv
// rtl/count_reg.sv - clearable up-counter with enable
module count_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear wins over increment so a fresh grant always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rr_select.sv
// rtl/rr_select.sv - round-robin pick of the first request after the last owner
module rr_select
  import bus_pkg::*;
(
  input  logic [3:0] req,
  input  midx_t      last,
  output midx_t      idx,
  output logic       any
);

  midx_t cand;

  // Walk offsets 4 down to 1 so the nearest requester after 'last' is the final
  // assignment; offset 4 wraps back to 'last' itself as the lowest priority.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = last + MIDX_W'(k);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - four-master round-robin bus arbiter with hold watchdog
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int BUS_WIDTH   = 32,
  parameter int CTRL_WIDTH  = 8,
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk50MHz,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            bus_req,
  output logic [NUM_MASTERS-1:0]            bus_ack,
  input  logic [NUM_MASTERS*BUS_WIDTH-1:0]  m_bus,
  input  logic [NUM_MASTERS*CTRL_WIDTH-1:0] m_ctrl,
  output logic [BUS_WIDTH-1:0]              bus_out,
  output logic [CTRL_WIDTH-1:0]             ctrl_out,
  output logic [1:0]                        owner,
  output logic                              owner_valid,
  output logic                              timeout_err
);

  bus_state_e state_q, state_d;
  midx_t      owner_q, owner_d;
  midx_t      last_q, last_d;
  logic       terr_q, terr_d;

  midx_t      rr_idx;
  logic       rr_any;
  logic [7:0] hold_cnt;
  logic       owner_req;
  logic       hold_expired;

  rr_select u_rr_select (
    .req  (bus_req),
    .last (last_q),
    .idx  (rr_idx),
    .any  (rr_any)
  );

  count_reg #(
    .WIDTH (8)
  ) u_hold_cnt (
    .clk_i  (clk50MHz),
    .rst_ni (rst_n),
    .clr_i  ((state_q == ST_IDLE) && rr_any),
    .en_i   (state_q == ST_GRANT),
    .cnt_o  (hold_cnt)
  );

  assign owner_req    = bus_req[owner_q];
  // The counter holds the number of completed grant cycles, so this is the
  // last cycle before it would reach TIMEOUT.
  assign hold_expired = (hold_cnt == 8'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a dropped request or an expired hold both end the grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (rr_any) state_d = ST_GRANT;
      ST_GRANT:   if (!owner_req || hold_expired) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Owner capture, last-owner update and watchdog flag for the next cycle.
  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    terr_d  = 1'b0;
    if ((state_q == ST_IDLE) && rr_any) begin
      owner_d = rr_idx;
    end
    if ((state_q == ST_GRANT) && (state_d == ST_RELEASE)) begin
      last_d = owner_q;
      // A voluntary release at the expiry cycle is not a watchdog event.
      terr_d = owner_req && hold_expired;
    end
  end

  // Datapath registers; last owner resets to 3 so master 0 is searched first.
  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= '0;
      last_q  <= 2'd3;
      terr_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      terr_q  <= terr_d;
    end
  end

  // Grant outputs and shared bus mux, decoded from the registered state and owner.
  always_comb begin
    bus_ack     = '0;
    owner_valid = 1'b0;
    bus_out     = '0;
    ctrl_out    = '0;
    if (state_q == ST_GRANT) begin
      bus_ack[owner_q] = 1'b1;
      owner_valid      = 1'b1;
      bus_out          = m_bus[int'(owner_q)*BUS_WIDTH +: BUS_WIDTH];
      ctrl_out         = m_ctrl[int'(owner_q)*CTRL_WIDTH +: CTRL_WIDTH];
    end
  end

  assign owner       = owner_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter
module tb_bus_arbiter;

  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic [3:0]  bus_req;
  logic [3:0]  bus_ack;
  logic [127:0] m_bus;
  logic [31:0] m_ctrl;
  logic [31:0] bus_out;
  logic [7:0]  ctrl_out;
  logic [1:0]  owner;
  logic        owner_valid;
  logic        timeout_err;

  logic [31:0] mb [4];
  logic [7:0]  mc [4];

  assign m_bus  = {mb[3], mb[2], mb[1], mb[0]};
  assign m_ctrl = {mc[3], mc[2], mc[1], mc[0]};

  bus_arbiter #(
    .BUS_WIDTH   (32),
    .CTRL_WIDTH  (8),
    .NUM_MASTERS (4),
    .TIMEOUT     (255)
  ) dut (
    .clk50MHz    (clk),
    .rst_n       (rst_n),
    .bus_req     (bus_req),
    .bus_ack     (bus_ack),
    .m_bus       (m_bus),
    .m_ctrl      (m_ctrl),
    .bus_out     (bus_out),
    .ctrl_out    (ctrl_out),
    .owner       (owner),
    .owner_valid (owner_valid),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  typedef struct {
    int owner;
    int gap;
    int len;
    bit to;
  } grant_t;

  grant_t exp_q[$];
  grant_t cur;
  int     n_tests;
  int     n_fail;
  int     grants_seen;
  bit     mon_en;
  bit     have_cur;
  bit     prev_valid;
  int     low_cnt;
  int     hold_len;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int o, input int g, input int l, input bit t);
    grant_t e;
    e.owner = o;
    e.gap   = g;
    e.len   = l;
    e.to    = t;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input int target, input int budget);
    int k;
    k = 0;
    while (grants_seen < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("grant_arrived", 64'(grants_seen >= target), 64'd1);
    #1;
  endtask

  // Monitor: pops an expected grant at each rising owner_valid and checks it.
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_valid = 1'b0;
        have_cur   = 1'b0;
        low_cnt    = -1;
      end else begin
        if (owner_valid && !prev_valid) begin
          grants_seen++;
          hold_len = 0;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_grant: owner=%0d granted, no grant expected", owner);
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
            if (cur.gap >= 0) check("turnaround_gap", 64'(low_cnt), 64'(cur.gap));
          end
        end
        if (owner_valid) begin
          hold_len++;
          if (have_cur) begin
            check("owner", 64'(owner), 64'(cur.owner));
            check("bus_ack", 64'(bus_ack), 64'(4'b0001 << cur.owner));
            check("bus_out", 64'(bus_out), 64'(mb[cur.owner]));
            check("ctrl_out", 64'(ctrl_out), 64'(mc[cur.owner]));
          end
          check("timeout_err_in_grant", 64'(timeout_err), 64'd0);
        end else begin
          check("idle_outputs_zero", 64'({bus_ack, bus_out, ctrl_out}), 64'd0);
          if (prev_valid) begin
            if (have_cur) begin
              if (cur.len >= 0) check("grant_length", 64'(hold_len), 64'(cur.len));
              check("timeout_err", 64'(timeout_err), 64'(cur.to));
            end
            have_cur = 1'b0;
            low_cnt  = 1;
          end else begin
            check("timeout_err_idle", 64'(timeout_err), 64'd0);
            if (low_cnt >= 0) low_cnt++;
          end
        end
        prev_valid = owner_valid;
      end
    end
  end

  initial begin
    int g0;
    n_tests     = 0;
    n_fail      = 0;
    grants_seen = 0;
    mon_en      = 1'b0;
    clk_en      = 1'b0;
    mb[0] = 32'h0A0A_0A0A; mc[0] = 8'h10;
    mb[1] = 32'hDEAD_BEEF; mc[1] = 8'h02;
    mb[2] = 32'h2222_3333; mc[2] = 8'h30;
    mb[3] = 32'h4444_5555; mc[3] = 8'h40;

    // Reset with all requests up and no clock running.
    rst_n   = 1'b1;
    bus_req = 4'b1111;
    #1 rst_n = 1'b0;
    #5;
    check("rst_bus_ack", 64'(bus_ack), 64'd0);
    check("rst_owner_valid", 64'(owner_valid), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    check("rst_bus_out", 64'(bus_out), 64'd0);

    bus_req = 4'b0000;
    clk_en  = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
    tick(2);

    // Masters 0 and 2 hold requests: watchdog alternates them 0, 2, 0.
    g0 = grants_seen;
    push_exp(0, -1, 255, 1'b1);
    push_exp(2, 2, 255, 1'b1);
    push_exp(0, 2, -1, 1'b0);
    bus_req = 4'b0101;
    wait_grants(g0 + 3, 1000);
    tick(10);
    bus_req = 4'b0000;
    tick(6);

    // Master 1 data path and zeroed bus in release.
    g0 = grants_seen;
    push_exp(1, -1, -1, 1'b0);
    bus_req = 4'b0010;
    wait_grants(g0 + 1, 10);
    tick(4);
    bus_req = 4'b0000;
    tick(6);

    // A request that drops before it is sampled gives no grant.
    g0 = grants_seen;
    bus_req = 4'b0010;
    @(negedge clk);
    #1 bus_req = 4'b0000;
    tick(6);
    check("glitch_no_grant", 64'(grants_seen), 64'(g0));

    // Master 2 pulses while master 0 owns the bus and is never granted.
    g0 = grants_seen;
    push_exp(0, -1, -1, 1'b0);
    bus_req = 4'b0001;
    wait_grants(g0 + 1, 10);
    tick(2);
    bus_req = 4'b0101;
    tick(1);
    bus_req = 4'b0001;
    tick(3);
    bus_req = 4'b0000;
    tick(8);
    check("pulse_no_grant", 64'(grants_seen), 64'(g0 + 1));

    // Master 3 held 300 cycles: watchdog after 255, re-granted 2 cycles later.
    g0 = grants_seen;
    push_exp(3, -1, 255, 1'b1);
    push_exp(3, 2, -1, 1'b0);
    bus_req = 4'b1000;
    tick(300);
    bus_req = 4'b0000;
    tick(6);
    check("timeout_regrant_count", 64'(grants_seen), 64'(g0 + 2));

    // Owner drops exactly at the expiry cycle: normal release, no timeout_err.
    push_exp(0, -1, 255, 1'b0);
    bus_req = 4'b0001;
    tick(255);
    bus_req = 4'b0000;
    tick(6);

    // Reset in the middle of a master 3 grant; master 0 wins afterwards.
    g0 = grants_seen;
    push_exp(3, -1, -1, 1'b0);
    bus_req = 4'b1000;
    wait_grants(g0 + 1, 10);
    tick(3);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midgrant_rst_bus_ack", 64'(bus_ack), 64'd0);
    check("midgrant_rst_owner_valid", 64'(owner_valid), 64'd0);
    check("midgrant_rst_owner", 64'(owner), 64'd0);
    bus_req = 4'b1001;
    @(posedge clk);
    #2;
    g0 = grants_seen;
    push_exp(0, -1, -1, 1'b0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    wait_grants(g0 + 1, 2);
    tick(3);
    bus_req = 4'b0000;
    tick(6);

    check("expected_grants_consumed", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
